// File: rtl/ccd_frame_seq_pkg.sv
// Shared definitions for the CCD vertical frame sequencer: state encodings,
// line-count width and default line geometry.
package ccd_frame_seq_pkg;

  localparam int CCD_FRAME_WD  = 13;
  localparam int CCD_LINE_PIX  = 1532;
  localparam int CCD_XSG_LINES = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XSG  = 3'd1,
    S_HEAD = 3'd2,
    S_GAP  = 3'd3,
    S_READ = 3'd4,
    S_TAIL = 3'd5,
    S_FILL = 3'd6
  } state_t;

  // Region flag vector {tail, read, head, xsg}; GAP, FILL and IDLE map to all-zero.
  function automatic logic [3:0] region_flags(input state_t s);
    return {s == S_TAIL, s == S_READ, s == S_HEAD, s == S_XSG};
  endfunction

endpackage

// File: rtl/ccd_frame_seq_if.sv
// Signal bundle between the frame sequencer, the register block that feeds it
// and the downstream clock generators.
interface ccd_frame_seq_if
  import ccd_frame_seq_pkg::*;
#(
  parameter int FRAME_WD = CCD_FRAME_WD
);

  logic                i_acq_en;
  logic                i_param_update;
  logic [FRAME_WD-1:0] iv_frame_period;
  logic [FRAME_WD-1:0] iv_headblank_end;
  logic [FRAME_WD-1:0] iv_vref_start;
  logic [FRAME_WD-1:0] iv_tailblank_start;
  logic [FRAME_WD-1:0] iv_tailblank_end;
  logic [FRAME_WD-1:0] iv_exp_start;

  logic                o_reg_active;
  logic [FRAME_WD-1:0] ov_line_cnt;
  logic [15:0]         ov_pix_cnt;
  logic                o_line_start;
  logic                o_frame_start;
  logic                o_exp_start;
  logic [2:0]          ov_state;
  logic                o_xsg;
  logic                o_headblank;
  logic                o_readout;
  logic                o_tailblank;

  // Host/register side: drives enables and timing values, observes the sequencer.
  modport master (
    output i_acq_en, i_param_update,
    output iv_frame_period, iv_headblank_end, iv_vref_start,
    output iv_tailblank_start, iv_tailblank_end, iv_exp_start,
    input  o_reg_active, ov_line_cnt, ov_pix_cnt,
    input  o_line_start, o_frame_start, o_exp_start,
    input  ov_state, o_xsg, o_headblank, o_readout, o_tailblank
  );

  // Sequencer side.
  modport slave (
    input  i_acq_en, i_param_update,
    input  iv_frame_period, iv_headblank_end, iv_vref_start,
    input  iv_tailblank_start, iv_tailblank_end, iv_exp_start,
    output o_reg_active, ov_line_cnt, ov_pix_cnt,
    output o_line_start, o_frame_start, o_exp_start,
    output ov_state, o_xsg, o_headblank, o_readout, o_tailblank
  );

endinterface

// File: rtl/ccd_line_cnt.sv
// Pixel/line counter pair for the frame sequencer. Counts while the sequencer
// is running, wraps lines at the effective frame period, parks at zero when
// idle, and produces the registered line/frame/exposure start pulses.
module ccd_line_cnt
  import ccd_frame_seq_pkg::*;
#(
  parameter int FRAME_WD = CCD_FRAME_WD,
  parameter int LINE_PIX = CCD_LINE_PIX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                acq_en,
  input  logic [FRAME_WD-1:0] period,
  input  logic [FRAME_WD-1:0] exp_line,
  output logic [FRAME_WD-1:0] line_cnt,
  output logic [FRAME_WD-1:0] next_line,
  output logic [15:0]         pix_cnt,
  output logic                last_pix,
  output logic                frame_end,
  output logic                line_start,
  output logic                frame_start,
  output logic                exp_start
);

  localparam logic [15:0]         PIX_LAST = 16'(LINE_PIX - 1);
  localparam logic [FRAME_WD-1:0] ONE      = {{(FRAME_WD-1){1'b0}}, 1'b1};

  logic last_line;
  logic exp_ok;

  assign last_pix  = (pix_cnt == PIX_LAST);
  assign last_line = (line_cnt == period - ONE);
  assign frame_end = run & last_pix & last_line;
  assign next_line = last_line ? '0 : line_cnt + ONE;
  // An exposure line at or beyond the period is never reached.
  assign exp_ok    = (exp_line < period);

  // Counter advance and start-of-line pulse generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      exp_start   <= 1'b0;
    end else if (!run) begin
      // Idle: hold at zero; an enable launches line 0 pix 0 on this edge.
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_start  <= acq_en;
      frame_start <= acq_en;
      exp_start   <= acq_en & exp_ok & (exp_line == '0);
    end else if (frame_end && !acq_en) begin
      // Frame finished with acquisition off: fall back to the idle values.
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      exp_start   <= 1'b0;
    end else if (last_pix) begin
      pix_cnt     <= '0;
      line_cnt    <= next_line;
      line_start  <= 1'b1;
      frame_start <= last_line;
      exp_start   <= exp_ok & (exp_line == next_line);
    end else begin
      pix_cnt     <= pix_cnt + 16'd1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      exp_start   <= 1'b0;
    end
  end

endmodule

// File: rtl/ccd_frame_seq.sv
// Vertical frame sequencer: steps through the XSG, head dump, gap, readout,
// tail dump and fill regions of each frame and only lets the register block
// take new host values at frame boundaries (or while idle).
module ccd_frame_seq
  import ccd_frame_seq_pkg::*;
#(
  parameter int FRAME_WD  = CCD_FRAME_WD,
  parameter int LINE_PIX  = CCD_LINE_PIX,
  parameter int XSG_LINES = CCD_XSG_LINES
) (
  input  logic           clk,
  input  logic           reset,
  ccd_frame_seq_if.slave bus
);

  localparam logic [FRAME_WD-1:0] XSG_END = FRAME_WD'(XSG_LINES);
  localparam logic [FRAME_WD-1:0] MIN_P   = FRAME_WD'(XSG_LINES + 1);

  state_t              state;
  state_t              next_region;
  logic [3:0]          flags;
  logic                upd_pending;
  logic                reg_active;
  logic                at_boundary;
  logic                run;
  logic [FRAME_WD-1:0] period_eff;
  logic [FRAME_WD-1:0] line_cnt;
  logic [FRAME_WD-1:0] next_line;
  logic [15:0]         pix_cnt;
  logic                last_pix;
  logic                frame_end;
  logic                line_start;
  logic                frame_start;
  logic                exp_start;

  // Half-open interval test; an interval with hi <= lo is empty.
  function automatic logic in_span(input logic [FRAME_WD-1:0] l,
                                   input logic [FRAME_WD-1:0] lo,
                                   input logic [FRAME_WD-1:0] hi);
    return (l >= lo) && (l < hi);
  endfunction

  // The frame must at least hold the XSG lines plus one more.
  assign period_eff = (bus.iv_frame_period > MIN_P) ? bus.iv_frame_period : MIN_P;
  assign run        = (state != S_IDLE);

  ccd_line_cnt #(
    .FRAME_WD (FRAME_WD),
    .LINE_PIX (LINE_PIX)
  ) u_line_cnt (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .acq_en      (bus.i_acq_en),
    .period      (period_eff),
    .exp_line    (bus.iv_exp_start),
    .line_cnt    (line_cnt),
    .next_line   (next_line),
    .pix_cnt     (pix_cnt),
    .last_pix    (last_pix),
    .frame_end   (frame_end),
    .line_start  (line_start),
    .frame_start (frame_start),
    .exp_start   (exp_start)
  );

  // Region of the upcoming line; first non-empty match wins, FILL is the fallback.
  always_comb begin
    next_region = S_FILL;
    if (next_line < XSG_END)
      next_region = S_XSG;
    else if (in_span(next_line, XSG_END, bus.iv_headblank_end))
      next_region = S_HEAD;
    else if (in_span(next_line, bus.iv_headblank_end, bus.iv_vref_start))
      next_region = S_GAP;
    else if (in_span(next_line, bus.iv_vref_start, bus.iv_tailblank_start))
      next_region = S_READ;
    else if (in_span(next_line, bus.iv_tailblank_start, bus.iv_tailblank_end))
      next_region = S_TAIL;
  end

  // Frame FSM: regions change only on the last pixel of a line, so state and
  // flags land together with pix 0 of the new line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      flags <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_acq_en) begin
            state <= S_XSG;
            flags <= region_flags(S_XSG);
          end
        end
        default: begin
          if (frame_end && !bus.i_acq_en) begin
            state <= S_IDLE;
            flags <= '0;
          end else if (last_pix) begin
            state <= next_region;
            flags <= region_flags(next_region);
          end
        end
      endcase
    end
  end

  // Host updates are held back until the last clock of a frame or any idle clock;
  // a pulse arriving on that very clock is taken at once.
  assign at_boundary = (state == S_IDLE) | frame_end;

  // Update arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_active  <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      reg_active <= at_boundary & (upd_pending | bus.i_param_update);
      if (at_boundary)
        upd_pending <= 1'b0;
      else if (bus.i_param_update)
        upd_pending <= 1'b1;
    end
  end

  assign bus.o_reg_active  = reg_active;
  assign bus.ov_line_cnt   = line_cnt;
  assign bus.ov_pix_cnt    = pix_cnt;
  assign bus.o_line_start  = line_start;
  assign bus.o_frame_start = frame_start;
  assign bus.o_exp_start   = exp_start;
  assign bus.ov_state      = state;
  assign bus.o_xsg         = flags[0];
  assign bus.o_headblank   = flags[1];
  assign bus.o_readout     = flags[2];
  assign bus.o_tailblank   = flags[3];

endmodule

// File: tb/tb_ccd_frame_seq.sv
// Directed bench for ccd_frame_seq with LINE_PIX=8, XSG_LINES=4.
module tb_ccd_frame_seq;

  localparam int LP = 8;

  logic clk = 1'b0;
  logic reset;

  int n_total = 0;
  int n_bad   = 0;
  int exp_st [0:31];

  ccd_frame_seq_if #(.FRAME_WD(13)) bus ();

  ccd_frame_seq #(
    .FRAME_WD  (13),
    .LINE_PIX  (LP),
    .XSG_LINES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_eq(input string tag, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input int p, input int hb, input int vr,
                          input int ts, input int te, input int ex);
    bus.iv_frame_period    = 13'(p);
    bus.iv_headblank_end   = 13'(hb);
    bus.iv_vref_start      = 13'(vr);
    bus.iv_tailblank_start = 13'(ts);
    bus.iv_tailblank_end   = 13'(te);
    bus.iv_exp_start       = 13'(ex);
  endtask

  task automatic fill_st(input int a, input int b, input int s);
    for (int l = a; l < b; l++) exp_st[l] = s;
  endtask

  task automatic expect_all_zero(input string tag);
    expect_eq({tag, "_state"}, int'(bus.ov_state), 0);
    expect_eq({tag, "_line"},  int'(bus.ov_line_cnt), 0);
    expect_eq({tag, "_pix"},   int'(bus.ov_pix_cnt), 0);
    expect_eq({tag, "_flags"}, int'({bus.o_tailblank, bus.o_readout, bus.o_headblank, bus.o_xsg}), 0);
    expect_eq({tag, "_pulses"}, int'({bus.o_line_start, bus.o_frame_start, bus.o_exp_start}), 0);
    expect_eq({tag, "_regact"}, int'(bus.o_reg_active), 0);
  endtask

  // Walks a frame from line 0 pix 0, checking every clock against exp_st.
  // upd_at/drop_at/rst_at are cycle indices within the frame (-1 = none).
  task automatic run_frame(input int nlines, input int exp_line, input int upd_at,
                           input int drop_at, input int rst_at, input bit ra_at0);
    int ln, px, st;
    for (int c = 0; c < nlines * LP; c++) begin
      ln = c / LP;
      px = c % LP;
      st = exp_st[ln];
      expect_eq("line", int'(bus.ov_line_cnt), ln);
      expect_eq("pix", int'(bus.ov_pix_cnt), px);
      expect_eq("state", int'(bus.ov_state), st);
      expect_eq("flags", int'({bus.o_tailblank, bus.o_readout, bus.o_headblank, bus.o_xsg}),
                int'({st == 5, st == 4, st == 2, st == 1}));
      expect_eq("line_start", int'(bus.o_line_start), int'(px == 0));
      expect_eq("frame_start", int'(bus.o_frame_start), int'(c == 0));
      expect_eq("exp_start", int'(bus.o_exp_start), int'(ln == exp_line && px == 0));
      expect_eq("reg_active", int'(bus.o_reg_active), int'(c == 0 && ra_at0));
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        expect_all_zero("async_rst");
        return;
      end
      bus.i_param_update = (c == upd_at);
      if (c == drop_at) bus.i_acq_en = 1'b0;
      tick();
    end
    bus.i_param_update = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.i_acq_en       = 1'b0;
    bus.i_param_update = 1'b0;
    set_regs(20, 6, 8, 16, 18, 10);
    repeat (2) tick();
    expect_all_zero("reset");

    reset = 1'b0;
    repeat (2) tick();
    expect_all_zero("idle");

    // Update pulse while idle: taken on that clock, visible the next one.
    bus.i_param_update = 1'b1;
    tick();
    bus.i_param_update = 1'b0;
    expect_eq("idle_upd_regact", int'(bus.o_reg_active), 1);
    tick();
    expect_eq("idle_upd_single", int'(bus.o_reg_active), 0);

    // Normal frame: XSG 0-3, HEAD 4-5, GAP 6-7, READ 8-15, TAIL 16-17, FILL 18-19.
    fill_st(0, 4, 1); fill_st(4, 6, 2); fill_st(6, 8, 3);
    fill_st(8, 16, 4); fill_st(16, 18, 5); fill_st(18, 20, 6);
    bus.i_acq_en = 1'b1;
    tick();
    expect_eq("start_latency_fs", int'(bus.o_frame_start), 1);
    // Update at line 9 is deferred to the frame boundary.
    run_frame(20, 10, 9 * LP, -1, -1, 1'b0);
    // Second frame: boundary pulse at line 19 pix 7, acq dropped at line 5.
    run_frame(20, 10, 19 * LP + 7, 5 * LP, -1, 1'b1);
    expect_eq("stop_regact", int'(bus.o_reg_active), 1);
    expect_eq("stop_state", int'(bus.ov_state), 0);
    expect_eq("stop_line", int'(bus.ov_line_cnt), 0);
    expect_eq("stop_pix", int'(bus.ov_pix_cnt), 0);
    expect_eq("stop_fs", int'(bus.o_frame_start), 0);
    tick();
    expect_all_zero("stopped");

    // Empty regions: XSG 0-3 straight into READ 4-15.
    set_regs(16, 4, 4, 16, 16, 10);
    fill_st(0, 4, 1); fill_st(4, 16, 4);
    bus.i_acq_en = 1'b1;
    tick();
    run_frame(16, 10, -1, 3, -1, 1'b0);
    expect_all_zero("empty_end");

    // Degenerate period: P=2 stretched to 5 lines, exposure line 7 never reached.
    set_regs(2, 4, 4, 4, 4, 7);
    fill_st(0, 4, 1); fill_st(4, 5, 6);
    bus.i_acq_en = 1'b1;
    tick();
    run_frame(5, -1, -1, -1, -1, 1'b0);

    // Back-to-back normal frame; pending update then reset at line 12 pix 3.
    set_regs(20, 6, 8, 16, 18, 10);
    fill_st(0, 4, 1); fill_st(4, 6, 2); fill_st(6, 8, 3);
    fill_st(8, 16, 4); fill_st(16, 18, 5); fill_st(18, 20, 6);
    run_frame(20, 10, 11 * LP, -1, 12 * LP + 3, 1'b0);
    bus.i_param_update = 1'b0;
    tick();
    expect_all_zero("in_reset");
    reset = 1'b0;
    tick();
    expect_eq("restart_fs", int'(bus.o_frame_start), 1);
    expect_eq("restart_state", int'(bus.ov_state), 1);
    expect_eq("restart_line", int'(bus.ov_line_cnt), 0);
    expect_eq("restart_pix", int'(bus.ov_pix_cnt), 0);
    expect_eq("restart_no_stale_upd", int'(bus.o_reg_active), 0);
    run_frame(2, 10, -1, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
